// File: rtl/pcie_fifo_unpack_pkg.sv
// Shared widths and encodings for the PCIe prefetch FIFO read side.
// The write (16->128) side uses the same widths.
package pcie_fifo_unpack_pkg;

  localparam int PIX_W      = 16;
  localparam int WORD_W     = 128;
  localparam int LANES      = 8;
  localparam int LANE_IDX_W = 3;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  function automatic logic [PIX_W-1:0] lane_pix(input logic [WORD_W-1:0]     w,
                                                input logic [LANE_IDX_W-1:0] idx);
    return w[idx*PIX_W +: PIX_W];
  endfunction

endpackage

// File: rtl/pcie_fifo_unpack.sv
// Pops 128-bit words from the prefetch FIFO and streams them out as eight
// 16-bit pixels each, with line/frame markers and an underrun counter.
module pcie_fifo_unpack
  import pcie_fifo_unpack_pkg::*;
#(
  parameter int LSB_FIRST   = 1,
  parameter int LINE_PIXELS = 1280,
  parameter int FRAME_LINES = 720
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  input  logic              fifo_rd_vld,
  input  logic [WORD_W-1:0] fifo_rd_data,
  output logic              fifo_rd_en,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_vld,
  input  logic              pix_rdy,
  output logic              pix_sol,
  output logic              pix_eol,
  output logic              pix_sof,
  output logic              frm_done,
  output logic [15:0]       underrun_cnt
);

  localparam logic [11:0]           PIX_LAST  = 12'(LINE_PIXELS - 1);
  localparam logic [11:0]           LINE_LAST = 12'(FRAME_LINES - 1);
  localparam logic [LANE_IDX_W-1:0] LANE_LAST = LANE_IDX_W'(LANES - 1);

  state_e                  state_q, state_d;
  logic [WORD_W-1:0]       word_buf_q, word_buf_d;
  logic [LANE_IDX_W-1:0]   lane_q, lane_d;
  logic [11:0]             pix_cnt_q, pix_cnt_d;
  logic [11:0]             line_cnt_q, line_cnt_d;
  logic                    frm_done_q, frm_done_d;
  logic [15:0]             underrun_q, underrun_d;

  logic accept, last_lane, eol_raw;

  assign pix_vld   = (state_q == ST_HOLD);
  assign accept    = pix_vld & pix_rdy;
  assign last_lane = (lane_q == LANE_LAST);
  assign eol_raw   = (pix_cnt_q == PIX_LAST);

  // Refill on the last-lane accept keeps the stream bubble-free across words.
  assign fifo_rd_en = ~rd_rst & fifo_rd_vld &
                      ((state_q == ST_EMPTY) | (pix_vld & last_lane & pix_rdy));

  generate
    if (LSB_FIRST != 0) begin : g_lsb
      assign pix_data = lane_pix(word_buf_q, lane_q);
    end else begin : g_msb
      assign pix_data = lane_pix(word_buf_q, ~lane_q);
    end
  endgenerate

  assign pix_sol      = pix_vld & (pix_cnt_q == 12'd0);
  assign pix_eol      = pix_vld & eol_raw;
  assign pix_sof      = pix_sol & (line_cnt_q == 12'd0);
  assign frm_done     = frm_done_q;
  assign underrun_cnt = underrun_q;

  always_comb begin
    state_d    = state_q;
    word_buf_d = word_buf_q;
    lane_d     = lane_q;
    pix_cnt_d  = pix_cnt_q;
    line_cnt_d = line_cnt_q;
    frm_done_d = 1'b0;
    underrun_d = underrun_q;

    if (fifo_rd_en) begin
      word_buf_d = fifo_rd_data;
      lane_d     = '0;
      state_d    = ST_HOLD;
    end else if (accept && last_lane) begin
      state_d    = ST_EMPTY;
    end else if (accept) begin
      lane_d     = lane_q + LANE_IDX_W'(1);
    end

    if (accept) begin
      if (eol_raw) begin
        pix_cnt_d  = '0;
        line_cnt_d = (line_cnt_q == LINE_LAST) ? 12'd0 : line_cnt_q + 12'd1;
        frm_done_d = (line_cnt_q == LINE_LAST);
      end else begin
        pix_cnt_d  = pix_cnt_q + 12'd1;
      end
    end

    // Only starvation inside a frame counts; idle time between frames is expected.
    if (pix_rdy && !pix_vld && ((pix_cnt_q | line_cnt_q) != 12'd0) &&
        (underrun_q != 16'hFFFF))
      underrun_d = underrun_q + 16'd1;
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state_q    <= ST_EMPTY;
      word_buf_q <= '0;
      lane_q     <= '0;
      pix_cnt_q  <= '0;
      line_cnt_q <= '0;
      frm_done_q <= 1'b0;
      underrun_q <= '0;
    end else begin
      state_q    <= state_d;
      word_buf_q <= word_buf_d;
      lane_q     <= lane_d;
      pix_cnt_q  <= pix_cnt_d;
      line_cnt_q <= line_cnt_d;
      frm_done_q <= frm_done_d;
      underrun_q <= underrun_d;
    end
  end

endmodule

// File: tb/tb_pcie_fifo_unpack.sv
// Scoreboard bench for pcie_fifo_unpack: 16-pixel lines, 2-line frames, plus an
// MSB-first instance for lane order.
module tb_pcie_fifo_unpack;

  logic         clk = 1'b0;
  logic         rd_rst = 1'b1;
  logic         fifo_rd_vld = 1'b0;
  logic [127:0] fifo_rd_data = '0;
  logic         fifo_rd_en;
  logic [15:0]  pix_data;
  logic         pix_vld, pix_sol, pix_eol, pix_sof, frm_done;
  logic         pix_rdy = 1'b0;
  logic [15:0]  underrun_cnt;

  logic         rst_m = 1'b1;
  logic         vld_m = 1'b0;
  logic [127:0] data_m = '0;
  logic         en_m, pvld_m, sol_m, eol_m, sof_m, fd_m;
  logic         rdy_m = 1'b1;
  logic [15:0]  pdata_m, ur_m;

  always #5 clk = ~clk;

  pcie_fifo_unpack #(.LSB_FIRST(1), .LINE_PIXELS(16), .FRAME_LINES(2)) dut (
    .rd_clk(clk), .rd_rst(rd_rst), .fifo_rd_vld(fifo_rd_vld), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en(fifo_rd_en), .pix_data(pix_data), .pix_vld(pix_vld), .pix_rdy(pix_rdy),
    .pix_sol(pix_sol), .pix_eol(pix_eol), .pix_sof(pix_sof), .frm_done(frm_done),
    .underrun_cnt(underrun_cnt));

  pcie_fifo_unpack #(.LSB_FIRST(0), .LINE_PIXELS(16), .FRAME_LINES(2)) dut_m (
    .rd_clk(clk), .rd_rst(rst_m), .fifo_rd_vld(vld_m), .fifo_rd_data(data_m),
    .fifo_rd_en(en_m), .pix_data(pdata_m), .pix_vld(pvld_m), .pix_rdy(rdy_m),
    .pix_sol(sol_m), .pix_eol(eol_m), .pix_sof(sof_m), .frm_done(fd_m),
    .underrun_cnt(ur_m));

  typedef struct packed {
    logic [15:0] d;
    logic        sol, eol, sof, last;
  } exp_t;

  exp_t         sb[$];
  logic [127:0] fifo_q[$];
  int           en_cyc[$];
  int chk = 0, err = 0;
  int idx = 0, popped = 0, limit = 1000000;
  int acc_cnt = 0, cyc = 0, t2_acc = 0, t2_gap = 0;
  int rdy_mode = 0;
  bit gap_en = 0, t2_on = 0, en_s = 0, rdy_tog = 0;
  bit fd_pend = 0, stall_prev = 0;
  logic [15:0] held = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Queue one word (8 pixels base..base+7) and its expected pixels with markers.
  task automatic push_word(input logic [15:0] base);
    logic [127:0] w;
    exp_t e;
    int p, l;
    for (int j = 0; j < 8; j++) begin
      w[j*16 +: 16] = base + 16'(j);
      p = idx % 16;
      l = (idx / 16) % 2;
      e.d    = base + 16'(j);
      e.sol  = (p == 0);
      e.eol  = (p == 15);
      e.sof  = (p == 0) && (l == 0);
      e.last = (p == 15) && (l == 1);
      sb.push_back(e);
      idx++;
    end
    fifo_q.push_back(w);
  endtask

  task automatic wait_acc(input int n, input int budget);
    int k = 0;
    while (acc_cnt < n && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    if (acc_cnt < n) check("timeout_acc", acc_cnt, n);
  endtask

  task automatic chk_zero(input string nm);
    check({nm, "_rd_en"}, fifo_rd_en, 0);
    check({nm, "_vld"}, pix_vld, 0);
    check({nm, "_data"}, pix_data, 0);
    check({nm, "_mark"}, {pix_sol, pix_eol, pix_sof}, 0);
    check({nm, "_fd"}, frm_done, 0);
    check({nm, "_ur"}, underrun_cnt, 0);
  endtask

  task automatic do_reset();
    rd_rst = 1'b1;
    sb.delete();
    fifo_q.delete();
    idx = 0;
    popped = 0;
    limit = 1000000;
    @(posedge clk); #1;
    rd_rst = 1'b0;
  endtask

  // FIFO model and pix_rdy driver; pops the word the DUT took at the last edge.
  always @(negedge clk) begin
    bit offer;
    if (en_s && fifo_q.size() > 0) begin
      void'(fifo_q.pop_front());
      popped++;
    end
    offer = (fifo_q.size() > 0) && (popped < limit) && !(gap_en && $urandom_range(0, 2) == 0);
    fifo_rd_vld = offer;
    fifo_rd_data = offer ? fifo_q[0] : '0;
    rdy_tog = ~rdy_tog;
    pix_rdy = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 2) ? rdy_tog : 1'b0;
  end

  // Monitor: samples just after the falling edge, what the next rising edge will see.
  always @(negedge clk) begin
    exp_t e;
    #1;
    cyc++;
    en_s = fifo_rd_en;
    if (!rd_rst) begin
      if (fifo_rd_en) check("rd_en_wo_vld", fifo_rd_vld, 1);
      if (t2_on && fifo_rd_en) en_cyc.push_back(cyc);
      if (stall_prev) check("stall_stable", pix_data, held);
      check("frm_done", frm_done, fd_pend);
      fd_pend = 0;
      if (t2_on && t2_acc > 0 && t2_acc < 32 && !pix_vld) t2_gap++;
      if (pix_vld && pix_rdy) begin
        acc_cnt++;
        if (t2_on) t2_acc++;
        if (sb.size() == 0) check("sb_empty", sb.size(), 1);
        else begin
          e = sb.pop_front();
          check("pix", {pix_data, pix_sol, pix_eol, pix_sof}, {e.d, e.sol, e.eol, e.sof});
          fd_pend = e.last;
        end
      end
      stall_prev = pix_vld && !pix_rdy;
      held = pix_data;
    end else begin
      fd_pend = 0;
      stall_prev = 0;
    end
  end

  // MSB-first lane order on the second instance.
  initial begin
    logic [127:0] w;
    for (int j = 0; j < 8; j++) w[j*16 +: 16] = 16'(8 - j);
    data_m = w;
    repeat (2) @(posedge clk);
    #1 rst_m = 1'b0;
    @(negedge clk);
    vld_m = 1'b1;
    #1 check("msb_rd_en", en_m, 1);
    @(negedge clk);
    vld_m = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1 check("msb_pix", {pvld_m, pdata_m}, {1'b1, 16'(i + 1)});
      @(negedge clk);
    end
    #1 check("msb_empty", pvld_m, 0);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 chk_zero("rst");
    rd_rst = 1'b0;

    // Reset in the middle of a word, at lane 3.
    rdy_mode = 1;
    push_word(16'h0100);
    wait_acc(3, 50);
    rd_rst = 1'b1;
    #1 chk_zero("midrst");
    do_reset();

    // Back-to-back stream: one full frame of 32 pixels.
    t2_on = 1;
    for (int k = 0; k < 4; k++) push_word(16'(8 * k));
    wait_acc(acc_cnt + 32, 200);
    repeat (3) @(posedge clk);
    #1 t2_on = 0;
    check("t2_en_n", en_cyc.size(), 4);
    for (int k = 1; k < 4; k++)
      if (en_cyc.size() > k) check("t2_en_off", en_cyc[k] - en_cyc[0], 8 * k);
    check("t2_gap", t2_gap, 0);
    check("t2_ur", underrun_cnt, 0);

    // Backpressure 1010 plus random FIFO gaps; same pixel sequence.
    rdy_mode = 2;
    gap_en = 1;
    for (int k = 0; k < 4; k++) push_word(16'(8 * k));
    wait_acc(acc_cnt + 32, 1000);
    gap_en = 0;
    repeat (3) @(posedge clk);
    #1;

    // Underrun: FIFO empty for exactly 5 cycles inside the frame.
    do_reset();
    rdy_mode = 1;
    limit = 2;
    for (int k = 0; k < 4; k++) push_word(16'(8 * k));
    wait_acc(acc_cnt + 16, 100);
    repeat (4) @(posedge clk);
    #1 limit = 4;
    wait_acc(acc_cnt + 16, 100);
    check("ur_5", underrun_cnt, 5);
    repeat (10) @(posedge clk);
    #1 check("ur_idle", underrun_cnt, 5);

    // Saturation from a preloaded FFFE.
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1 force dut.underrun_q = 16'hFFFE;
    @(posedge clk); #1;
    release dut.underrun_q;
    check("ur_fffe", underrun_cnt, 16'hFFFE);
    rdy_mode = 1;
    limit = 5;
    push_word(16'h0040);
    wait_acc(acc_cnt + 8, 100);
    repeat (6) @(posedge clk);
    #1 check("ur_sat", underrun_cnt, 16'hFFFF);
    check("sb_drain", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule
